// File: rtl/hydra_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hydra_pkg
// Description : Shared definitions for the port scheduler: queue count,
//               priority index type, credit type, FSM state encoding and
//               the credit reload value.
// Revision    : 1.0 - initial release
// ============================================================================
package hydra_pkg;

  localparam int NPRIO    = 8;
  localparam int PRIO_W   = 3;
  localparam int CREDIT_W = 4;

  typedef logic [PRIO_W-1:0]   prio_t;
  typedef logic [CREDIT_W-1:0] credit_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_RELOAD = 3'd2,
    ST_GRANT  = 3'd3,
    ST_XFER   = 3'd4
  } state_e;

  // Full credit for queue p: higher priorities get proportionally more slots.
  function automatic credit_t credit_full(input int p);
    return credit_t'(p + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/port_wrr_scheduler_prio_pick.sv
`default_nettype none
// ============================================================================
// Module      : prio_pick
// Description : Highest-index selector over an N-bit request mask.
// Ports       : mask  - request bits, bit N-1 has highest priority
//               found - at least one mask bit is set
//               idx   - index of the highest set bit (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
module prio_pick
  import hydra_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] mask,
  output logic         found,
  output prio_t        idx
);

  // Ascending scan: the last set bit seen (the highest) wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        found = 1'b1;
        idx   = prio_t'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/port_wrr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : port_wrr_scheduler
// Description : Per-output-port packet scheduler selecting one of NPRIO
//               queues, either strict priority or credit-based weighted
//               round-robin (queue p gets p+1 grants per round).
// Ports       : clk, rst_n      - clock, synchronous active-low reset
//               wrr_en          - 1 = WRR, 0 = strict (sampled in ARB only)
//               ready           - downstream port can accept a packet
//               q_vld[NPRIO]    - queue holds a complete packet
//               grant_vld/prio  - selected queue, held until grant_ack
//               grant_ack       - read engine accepted the grant
//               pkt_done        - read engine finished the packet
//               busy            - scheduler not in IDLE
//               grant_cnt       - per-queue accepted grant counters,
//                                 only with SCHED_STATS_EN defined
// Config      : `define SCHED_STATS_EN to add the grant_cnt statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module port_wrr_scheduler
  import hydra_pkg::*;
#(
  parameter int NPRIO = hydra_pkg::NPRIO,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrr_en,
  input  logic             ready,
  input  logic [NPRIO-1:0] q_vld,
  output logic             grant_vld,
  output logic [2:0]       grant_prio,
  input  logic             grant_ack,
  input  logic             pkt_done,
  output logic             busy
`ifdef SCHED_STATS_EN
  ,
  output logic [NPRIO*CNT_W-1:0] grant_cnt
`endif
);

  state_e     state_q, state_d;
  prio_t      grant_prio_q, grant_prio_d;
  logic       wrr_mode_q, wrr_mode_d;   // wrr_en captured at arbitration
  credit_t    credit_q [NPRIO];
  credit_t    credit_d [NPRIO];

  logic [NPRIO-1:0] credit_nz;
  logic             any_found, wrr_found;
  prio_t            any_idx, wrr_idx;
  logic             accept;

  for (genvar p = 0; p < NPRIO; p++) begin : g_credit_nz
    assign credit_nz[p] = |credit_q[p];
  end

  prio_pick #(.N(NPRIO)) u_pick_strict (
    .mask  (q_vld),
    .found (any_found),
    .idx   (any_idx)
  );

  prio_pick #(.N(NPRIO)) u_pick_wrr (
    .mask  (q_vld & credit_nz),
    .found (wrr_found),
    .idx   (wrr_idx)
  );

  assign accept = (state_q == ST_GRANT) && grant_ack;

  always_comb begin
    state_d      = state_q;
    grant_prio_d = grant_prio_q;
    wrr_mode_d   = wrr_mode_q;
    credit_d     = credit_q;
    case (state_q)
      ST_IDLE: begin
        if (ready && (|q_vld)) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (!any_found) begin
          state_d = ST_IDLE;
        end else if (!wrr_en) begin
          state_d      = ST_GRANT;
          grant_prio_d = any_idx;
          wrr_mode_d   = 1'b0;
        end else if (wrr_found) begin
          state_d      = ST_GRANT;
          grant_prio_d = wrr_idx;
          wrr_mode_d   = 1'b1;
        end else begin
          // Valid queues exist but the round is exhausted.
          state_d = ST_RELOAD;
        end
      end
      ST_RELOAD: begin
        for (int p = 0; p < NPRIO; p++) credit_d[p] = credit_full(p);
        state_d = ST_ARB;
      end
      ST_GRANT: begin
        if (grant_ack) begin
          state_d = ST_XFER;
          // Nonzero check keeps the credit from wrapping below zero.
          if (wrr_mode_q && (credit_q[grant_prio_q] != '0))
            credit_d[grant_prio_q] = credit_q[grant_prio_q] - credit_t'(1);
        end
      end
      ST_XFER: begin
        if (pkt_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_prio_q <= '0;
      wrr_mode_q   <= 1'b0;
      for (int p = 0; p < NPRIO; p++) credit_q[p] <= credit_full(p);
    end else begin
      state_q      <= state_d;
      grant_prio_q <= grant_prio_d;
      wrr_mode_q   <= wrr_mode_d;
      credit_q     <= credit_d;
    end
  end

  assign grant_vld  = (state_q == ST_GRANT);
  assign grant_prio = grant_prio_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef SCHED_STATS_EN
  logic [CNT_W-1:0] cnt_q [NPRIO];
  logic [CNT_W-1:0] cnt_d [NPRIO];

  always_comb begin
    cnt_d = cnt_q;
    // Natural wrap at 2^CNT_W.
    if (accept) cnt_d[grant_prio_q] = cnt_q[grant_prio_q] + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < NPRIO; p++) cnt_q[p] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar p = 0; p < NPRIO; p++) begin : g_cnt_out
    assign grant_cnt[p*CNT_W +: CNT_W] = cnt_q[p];
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
`default_nettype wire

// File: tb/tb_port_wrr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_port_wrr_scheduler
// Description : Self-checking bench for port_wrr_scheduler. Directed steps
//               plus randomized packets compared with a queue/credit model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_port_wrr_scheduler;

  logic       clk = 1'b0;
  logic       rst_n, wrr_en, ready, grant_ack, pkt_done;
  logic [7:0] q_vld;
  logic       grant_vld, busy;
  logic [2:0] grant_prio;
`ifdef SCHED_STATS_EN
  logic [8*16-1:0] grant_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: remaining credits and accepted grants per queue.
  int cred    [8];
  int exp_cnt [8];
  int g_last;

  port_wrr_scheduler #(.NPRIO(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wrr_en     (wrr_en),
    .ready      (ready),
    .q_vld      (q_vld),
    .grant_vld  (grant_vld),
    .grant_prio (grant_prio),
    .grant_ack  (grant_ack),
    .pkt_done   (pkt_done),
    .busy       (busy)
`ifdef SCHED_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 8; p++) begin
      cred[p]    = p + 1;
      exp_cnt[p] = 0;
    end
  endtask

  // Which queue should win for this request set; refills the round when
  // WRR finds no queue with both a packet and credit left.
  task automatic model_pick(input logic [7:0] q, input bit wrr,
                            output int p_out, output bit reload);
    p_out  = -1;
    reload = 1'b0;
    if (wrr) begin
      for (int p = 0; p < 8; p++) if (q[p] && cred[p] > 0) p_out = p;
      if (p_out < 0) begin
        reload = 1'b1;
        for (int p = 0; p < 8; p++) cred[p] = p + 1;
      end
    end
    if (p_out < 0) for (int p = 0; p < 8; p++) if (q[p]) p_out = p;
  endtask

  task automatic model_accept(input int p, input bit wrr);
    if (wrr) cred[p] = cred[p] - 1;
    exp_cnt[p] = (exp_cnt[p] + 1) % 65536;
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 20 && !grant_vld; i++) tick();
    chk("grant_timeout", 32'(grant_vld), 32'd1);
  endtask

  // One full packet from IDLE: arbitration, handshake, transfer, done.
  task automatic do_packet(input logic [7:0] q, input bit wrr, input int ack_dly,
                           input int xfer_len, input bit check_lat, input bit scramble);
    int  exp_p;
    bit  reload;
    model_pick(q, wrr, exp_p, reload);
    ready  = 1'b1;
    q_vld  = q;
    wrr_en = wrr;
    if (check_lat && !reload) begin
      tick();
      chk("lat_arb_vld", 32'(grant_vld), 32'd0);
      chk("lat_arb_busy", 32'(busy), 32'd1);
      tick();
      chk("lat_grant_vld", 32'(grant_vld), 32'd1);
    end else begin
      wait_grant();
    end
    chk("grant_prio", 32'(grant_prio), 32'(exp_p));
    g_last = int'(grant_prio);
    if (scramble) begin
      ready  = 1'($urandom);
      q_vld  = 8'($urandom);
      wrr_en = 1'($urandom);
    end
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      chk("hold_vld", 32'(grant_vld), 32'd1);
      chk("hold_prio", 32'(grant_prio), 32'(exp_p));
    end
    grant_ack = 1'b1;
    tick();
    grant_ack = 1'b0;
    chk("xfer_vld", 32'(grant_vld), 32'd0);
    chk("xfer_busy", 32'(busy), 32'd1);
    model_accept(exp_p, wrr);
    for (int i = 0; i < xfer_len; i++) begin
      tick();
      chk("xfer_hold", 32'(busy), 32'd1);
    end
    pkt_done = 1'b1;
    ready    = 1'b0;
    q_vld    = 8'h00;
    tick();
    pkt_done = 1'b0;
    chk("done_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int exp_p;
    bit reload;
    int seq_wrr [6];
    seq_wrr = '{3, 3, 3, 3, 0, 3};

    rst_n = 1'b0; wrr_en = 1'b0; ready = 1'b0; q_vld = 8'h00;
    grant_ack = 1'b0; pkt_done = 1'b0; g_last = 0;
    model_reset();
    tick(); tick(); tick();
    chk("rst_vld", 32'(grant_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_prio", 32'(grant_prio), 32'd0);
    rst_n = 1'b1;
    tick();

    // Strict priority: queue 7 beats 3, twice in a row.
    do_packet(8'h88, 1'b0, 1, 2, 1'b1, 1'b0);
    chk("strict_first", 32'(g_last), 32'd7);
    do_packet(8'h88, 1'b0, 0, 1, 1'b1, 1'b0);
    chk("strict_second", 32'(g_last), 32'd7);

    // Backpressure: no grant while ready is low.
    ready = 1'b0; q_vld = 8'h08;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_no_grant", 32'(grant_vld | busy), 32'd0);
    end
    do_packet(8'h08, 1'b0, 0, 1, 1'b1, 1'b0);
    chk("bp_prio", 32'(g_last), 32'd3);

    // Long handshake stall, then a zero-wait ack.
    do_packet(8'h08, 1'b0, 5, 0, 1'b1, 1'b0);
    do_packet(8'h04, 1'b0, 0, 0, 1'b1, 1'b0);

    // WRR between queues 3 and 0 with full credits.
    for (int i = 0; i < 6; i++) begin
      do_packet(8'h09, 1'b1, 0, 1, 1'b1, 1'b0);
      chk("wrr_seq", 32'(g_last), 32'(seq_wrr[i]));
    end

    // Reset in XFER abandons the grant and restores credits.
    model_pick(8'h09, 1'b1, exp_p, reload);
    ready = 1'b1; q_vld = 8'h09; wrr_en = 1'b1;
    wait_grant();
    chk("pre_rst_prio", 32'(grant_prio), 32'(exp_p));
    grant_ack = 1'b1;
    tick();
    grant_ack = 1'b0;
    ready = 1'b0; q_vld = 8'h00;
    rst_n = 1'b0;
    tick();
    chk("xfer_rst_busy", 32'(busy), 32'd0);
    chk("xfer_rst_vld", 32'(grant_vld), 32'd0);
    chk("xfer_rst_prio", 32'(grant_prio), 32'd0);
    rst_n = 1'b1;
    model_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      do_packet(8'h09, 1'b1, 1, 0, 1'b1, 1'b0);
      chk("post_rst_wrr", 32'(g_last), (i < 4) ? 32'd3 : 32'd0);
    end

    // Spurious pkt_done in IDLE is ignored.
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    chk("spurious_done", 32'(busy | grant_vld), 32'd0);

    // Randomized traffic with inputs scrambled during GRANT/XFER.
    for (int n = 0; n < 40; n++) begin
      do_packet(8'($urandom_range(1, 255)), 1'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'b1, 1'b1);
    end

`ifdef SCHED_STATS_EN
    for (int p = 0; p < 8; p++) begin
      chk("grant_cnt", 32'(grant_cnt[p*16 +: 16]), 32'(exp_cnt[p]));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/port_wrr_scheduler.md
PORT_WRR_SCHEDULER -- requirements
Module: port_wrr_scheduler

Interface
REQ-001 SHALL have parameter NPRIO, default 8: number of priority queues per output port; priority 7 is highest.
REQ-002 SHALL have parameter CNT_W, default 16: width of each statistics counter.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port wrr_en, input, 1: 1 = weighted round-robin, 0 = strict priority.
REQ-006 SHALL have port ready, input, 1: downstream output port can accept a packet.
REQ-007 SHALL have port q_vld, input, NPRIO: bit p high = queue p holds at least one complete packet.
REQ-008 SHALL have port grant_vld, output, 1: a queue is selected for readout.
REQ-009 SHALL have port grant_prio, output, 3: index of the selected queue.
REQ-010 SHALL have port grant_ack, input, 1: read engine accepted the grant.
REQ-011 SHALL have port pkt_done, input, 1: read engine finished the packet (rd_eop emitted).
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port grant_cnt, output, NPRIO x CNT_W, present only when SCHED_STATS_EN is defined: accepted grants per queue.

Function
REQ-014 SHALL implement FSM states IDLE, ARB, RELOAD, GRANT, XFER.
REQ-015 SHALL go IDLE->ARB when ready && |q_vld is sampled in IDLE; otherwise SHALL stay in IDLE.
REQ-016 SHALL, in ARB with wrr_en=0, select the highest p with q_vld[p] and go to GRANT.
REQ-017 SHALL, in ARB with wrr_en=1, select the highest p with q_vld[p] && credit[p]>0 and go to GRANT; if valid queues exist but none has credit, SHALL go to RELOAD.
REQ-018 SHALL, in RELOAD (exactly 1 cycle), set credit[p]=p+1 for all p, then return to ARB.
REQ-019 SHALL, in ARB with q_vld==0, return to IDLE without granting.
REQ-020 SHALL register grant_prio in ARB and hold grant_vld=1 and grant_prio stable throughout GRANT.
REQ-021 SHALL assert grant_vld 2 cycles after ready && |q_vld is first sampled in IDLE when no RELOAD occurs, and 3 cycles after when RELOAD occurs.
REQ-022 SHALL go GRANT->XFER on the cycle grant_ack=1, including when grant_ack is high in the first GRANT cycle; grant_vld SHALL be 0 from the next cycle.
REQ-023 SHALL, on grant acceptance with wrr_en=1, decrement credit[grant_prio] by 1; credits SHALL NOT change when wrr_en=0.
REQ-024 SHALL ignore changes to ready, q_vld and wrr_en during GRANT and XFER; wrr_en SHALL be sampled only in ARB.
REQ-025 SHALL go XFER->IDLE on pkt_done; pkt_done outside XFER SHALL be ignored.
REQ-026 SHALL never let credit underflow below 0 or exceed p+1; credit width SHALL be 4 bits.

Reset
REQ-027 SHALL, on rst_n=0 at a rising edge, enter IDLE from any state and drive grant_vld=0, grant_prio=0, busy=0.
REQ-028 SHALL, on reset, set credit[p]=p+1 and (if present) grant_cnt=0; a reset mid-GRANT or mid-XFER SHALL abandon that grant.

Configuration
REQ-029 SHALL, with SCHED_STATS_EN defined, increment grant_cnt[grant_prio] on each accepted grant, wrapping from 2^CNT_W-1 to 0.
REQ-030 SHALL, without SCHED_STATS_EN, omit the grant_cnt port and its counters; all other behaviour SHALL be identical.

Structure
REQ-031 SHALL take NPRIO, the priority index type and the FSM state enum from shared package hydra_pkg.
REQ-032 SHALL place the masked highest-index selector in sub-module prio_pick, which takes an NPRIO-bit mask and returns found and index.

Verification
REQ-033 Strict: wrr_en=0, ready=1, q_vld=8'b1000_1000 -> grant_prio=7 at IDLE+2; after ack and pkt_done, next grant=7 again.
REQ-034 WRR: wrr_en=0 (credit untouched) then wrr_en=1, q_vld=8'b0000_1001 held, every grant acked and done -> grant sequence 3,3,3,3,0, RELOAD, 3,...
REQ-035 Backpressure: ready=0, q_vld=8'h08 for 20 cycles -> no grant_vld; ready=1 -> grant_vld at +2 cycles, prio=3.
REQ-036 Handshake: grant_ack held 0 for 5 cycles -> grant_vld and grant_prio stable; ack in the same cycle grant_vld rises -> XFER next cycle.
REQ-037 Reset: rst_n=0 in XFER -> IDLE, busy=0, grant_vld=0 next cycle; credits back to p+1 (next WRR grant from queue 3 repeats 4x).
REQ-038 Stats (SCHED_STATS_EN): 5 acked grants on queue 3 -> grant_cnt[3]=5, others 0; spurious pkt_done in IDLE -> no state change.
